cpu_axi_bridge: RTL and testbench
=================================

Name: cpu_axi_bridge

Overview:
- Converts the CPU's sram-like inst/data request ports (req/addr_ok/data_ok handshake) into one AXI3 master.
- Sits directly downstream of the core top and replaces the direct SRAM hookup.
- Supports one outstanding read and one outstanding write, with single-beat transfers only.

Parameters:
- DATA_ARID, default 4'd1, ARID driven for data-port reads; inst reads always use ARID 4'd0.

Ports:
- clk  in  1  sole clock.
- resetn  in  1  asynchronous active-low reset.
- inst_sram_req  in  1  inst read request; always word-sized.
- inst_sram_addr  in  32  inst byte address.
- inst_sram_addr_ok  out  1  inst request accepted this cycle.
- inst_sram_data_ok  out  1  one-cycle pulse when inst_sram_rdata is valid.
- inst_sram_rdata  out  32  returned instruction.
- data_sram_req  in  1  data request.
- data_sram_wr  in  1  1 = store, 0 = load.
- data_sram_size  in  2  0 = byte, 1 = half, 2 = word.
- data_sram_addr  in  32  data byte address.
- data_sram_wstrb  in  4  byte strobes for stores.
- data_sram_wdata  in  32  store data.
- data_sram_addr_ok  out  1  data request accepted this cycle.
- data_sram_data_ok  out  1  one-cycle pulse at load data return or store completion.
- data_sram_rdata  out  32  load data.
- arid  out  4  read ID.
- araddr  out  32  read address.
- arsize  out  3  {1'b0,size}.
- arvalid  out  1  read address valid.
- arready  in  1  read address ready.
- rdata  in  32  read data.
- rvalid  in  1  read data valid.
- rready  out  1  read data ready.
- awaddr  out  32  write address.
- awsize  out  3  {1'b0,size}.
- awvalid  out  1  write address valid.
- awready  in  1  write address ready.
- wdata  out  32  write data.
- wstrb  out  4  write strobes.
- wvalid  out  1  write data valid.
- wready  in  1  write data ready.
- bvalid  in  1  write response valid.
- bready  out  1  write response ready.

Behaviour:
- Reset: asynchronous, active-low.
  - All valids, rready, bready, data_ok outputs, rdata outputs, arid, addresses and strobes go to 0.
  - Both FSMs go to IDLE.
  - Reset mid-transfer abandons the transfer; the AXI slave is reset by the same resetn.
- Read FSM states: R_IDLE -> R_AR (arvalid=1, held stable until arready) -> R_R (rready=1, until rvalid) -> R_IDLE.
- Write FSM states: W_IDLE -> W_AW (awvalid and wvalid both asserted) -> W_B (bready=1, until bvalid) -> W_IDLE.
  - In W_AW, awvalid drops after its own handshake and wvalid drops after its own handshake; either order or the same cycle is legal.
  - Transition to W_B once both handshakes are done.
- Acceptance rules (combinational; the request is latched on the addr_ok cycle):
  - data_sram_addr_ok = data_sram_req & R_IDLE & W_IDLE for loads.
  - data_sram_addr_ok = data_sram_req & W_IDLE & no data load outstanding for stores.
  - inst_sram_addr_ok = inst_sram_req & R_IDLE & ~(data_sram_req & ~data_sram_wr).
  - Data loads win read arbitration over inst fetches.
  - The data port is strictly in-order with at most one outstanding request.
- AXI channel behaviour:
  - arvalid/awvalid/wvalid first rise the cycle after acceptance.
  - AXI address/strobe/data fields come from the latched request; no combinational input-to-AXI path.
- Response timing:
  - On the rvalid&rready cycle: rdata is registered into the matching port's rdata, and that port's data_ok pulses the next cycle.
  - On the bvalid&bready cycle: data_sram_data_ok pulses the next cycle.
  - Minimum load latency: accept at T, arvalid at T+1, rvalid at T+2, data_ok at T+3.
- The bridge never cancels a request; requesters hold req/addr until addr_ok.
- An inst fetch waits only for R_IDLE, so it may overlap a store.

Optional Feature:
- Macro: AXI_RDATA_BYPASS_EN.
  - Defined: the selected port's data_ok = rvalid in R_R and its rdata = AXI rdata combinationally, giving load latency T+2.
  - Undefined: registered return as above.
  - Write path is identical in both cases.

Test Plan:
- Inst read 0x1c000000, arready at T+1, rvalid at T+2 with 0x02800404 -> arid=0, arsize=3'd2, one inst_sram_data_ok pulse at T+3 with rdata 0x02800404.
- Inst and data load requested in the same cycle -> data accepted (arid=1), inst_sram_addr_ok stays 0 until R_IDLE returns, then the inst fetch is issued.
- Byte store addr 0x00000103, wstrb 4'b1000, wdata 0xAB000000, wready immediate, awready delayed 3 cycles -> wvalid high 1 cycle, awvalid high 3 cycles, bready then one data_ok pulse.
- Load requested while a store sits in W_B -> data_sram_addr_ok=0 until the store's data_ok; resetn dropped while in R_AR -> arvalid=0 immediately, FSMs in IDLE.

Source files
------------

// File: rtl/cpu_axi_bridge.sv
// cpu_axi_bridge: turns the core's sram-like inst/data request ports into a
// single AXI3 master. One read and one write may be outstanding at a time,
// and every transfer is a single beat.
// Optional feature macro: AXI_RDATA_BYPASS_EN -- when defined, read data and
// the matching data_ok come straight from the R channel in the R_R state
// instead of one cycle later from registers.
//
// Handshake rule, for every AXI channel: a transfer happens on a cycle where
// valid and ready are both 1; once valid rises, it and its payload stay
// stable until that cycle, and ready may be asserted independently of valid.
// On the CPU side a request is taken on the cycle where req & addr_ok.
module cpu_axi_bridge #(
  parameter logic [3:0] DATA_ARID = 4'd1
) (
  input  logic        clk,
  input  logic        resetn,
  // instruction port
  input  logic        inst_sram_req,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  // data port
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  // AXI read address / data
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  // AXI write address / data / response
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready,
  // FSM state visibility
  output logic [1:0]  rd_state_dbg,
  output logic [1:0]  wr_state_dbg
);

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_AR = 2'd1, R_R = 2'd2} rd_state_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_AW = 2'd1, W_B = 2'd2} wr_state_t;

  rd_state_t rd_state, rd_next;
  wr_state_t wr_state, wr_next;

  logic rd_is_data;          // read in flight belongs to the data port
  logic aw_done, w_done;     // per-channel handshake already completed in W_AW
  logic data_wr_ok_q;        // store completion pulse

  logic r_idle, w_idle;
  logic data_load_req, data_store_req, data_load_busy;
  logic load_acc, store_acc, inst_acc, rd_acc;
  logic rd_hs;
  logic inst_rd_ok, data_rd_ok;

  assign r_idle         = (rd_state == R_IDLE);
  assign w_idle         = (wr_state == W_IDLE);
  assign data_load_req  = data_sram_req & ~data_sram_wr;
  assign data_store_req = data_sram_req &  data_sram_wr;
  assign data_load_busy = ~r_idle & rd_is_data;

  // Loads need both sides idle so the data port stays strictly in order;
  // loads also take priority over inst fetches for the read channel.
  assign data_sram_addr_ok = (data_load_req & r_idle & w_idle) |
                             (data_store_req & w_idle & ~data_load_busy);
  assign inst_sram_addr_ok = inst_sram_req & r_idle & ~data_load_req;

  assign load_acc  = data_load_req  & data_sram_addr_ok;
  assign store_acc = data_store_req & data_sram_addr_ok;
  assign inst_acc  = inst_sram_addr_ok;
  assign rd_acc    = load_acc | inst_acc;
  assign rd_hs     = rvalid & rready;

  assign rd_state_dbg = rd_state;
  assign wr_state_dbg = wr_state;

  // Read FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rd_state <= R_IDLE;
    else         rd_state <= rd_next;
  end

  // Read FSM next state and AR/R channel controls
  always_comb begin
    rd_next = rd_state;
    arvalid = 1'b0;
    rready  = 1'b0;
    case (rd_state)
      R_IDLE: if (rd_acc) rd_next = R_AR;
      R_AR: begin
        arvalid = 1'b1;
        if (arready) rd_next = R_R;
      end
      R_R: begin
        rready = 1'b1;
        if (rvalid) rd_next = R_IDLE;
      end
      default: rd_next = R_IDLE;
    endcase
  end

  // Latch the accepted read request; AR fields never come from the inputs directly
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_is_data <= 1'b0;
      arid       <= 4'd0;
      araddr     <= 32'd0;
      arsize     <= 3'd0;
    end else if (r_idle && rd_acc) begin
      rd_is_data <= load_acc;
      arid       <= load_acc ? DATA_ARID : 4'd0;
      araddr     <= load_acc ? data_sram_addr : inst_sram_addr;
      arsize     <= load_acc ? {1'b0, data_sram_size} : 3'd2;
    end
  end

`ifdef AXI_RDATA_BYPASS_EN
  // Read return straight from the R channel during the handshake cycle
  assign inst_rd_ok      = rd_hs & ~rd_is_data;
  assign data_rd_ok      = rd_hs &  rd_is_data;
  assign inst_sram_rdata = inst_rd_ok ? rdata : 32'd0;
  assign data_sram_rdata = data_rd_ok ? rdata : 32'd0;
`else
  logic        inst_rd_ok_q, data_rd_ok_q;
  logic [31:0] inst_rdata_q, data_rdata_q;

  // Capture read data on the R handshake and pulse data_ok one cycle later
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_rd_ok_q <= 1'b0;
      data_rd_ok_q <= 1'b0;
      inst_rdata_q <= 32'd0;
      data_rdata_q <= 32'd0;
    end else begin
      inst_rd_ok_q <= rd_hs & ~rd_is_data;
      data_rd_ok_q <= rd_hs &  rd_is_data;
      if (rd_hs && !rd_is_data) inst_rdata_q <= rdata;
      if (rd_hs &&  rd_is_data) data_rdata_q <= rdata;
    end
  end

  assign inst_rd_ok      = inst_rd_ok_q;
  assign data_rd_ok      = data_rd_ok_q;
  assign inst_sram_rdata = inst_rdata_q;
  assign data_sram_rdata = data_rdata_q;
`endif

  assign inst_sram_data_ok = inst_rd_ok;
  assign data_sram_data_ok = data_rd_ok | data_wr_ok_q;

  // Write FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) wr_state <= W_IDLE;
    else         wr_state <= wr_next;
  end

  // Write FSM next state and AW/W/B channel controls
  always_comb begin
    wr_next = wr_state;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    case (wr_state)
      W_IDLE: if (store_acc) wr_next = W_AW;
      W_AW: begin
        awvalid = ~aw_done;
        wvalid  = ~w_done;
        // AW and W finish independently; move on once both have completed
        if ((aw_done | awready) && (w_done | wready)) wr_next = W_B;
      end
      W_B: begin
        bready = 1'b1;
        if (bvalid) wr_next = W_IDLE;
      end
      default: wr_next = W_IDLE;
    endcase
  end

  // Latch the accepted store and track which of AW/W has handshaken
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      awaddr  <= 32'd0;
      awsize  <= 3'd0;
      wdata   <= 32'd0;
      wstrb   <= 4'd0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (w_idle && store_acc) begin
      awaddr  <= data_sram_addr;
      awsize  <= {1'b0, data_sram_size};
      wdata   <= data_sram_wdata;
      wstrb   <= data_sram_wstrb;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (wr_state == W_AW) begin
      if (awvalid && awready) aw_done <= 1'b1;
      if (wvalid && wready)   w_done  <= 1'b1;
    end
  end

  // Store completion pulse, one cycle after the B handshake
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) data_wr_ok_q <= 1'b0;
    else         data_wr_ok_q <= bvalid & bready;
  end

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// tb_cpu_axi_bridge: directed bench for cpu_axi_bridge. Stimulus pushes the
// expected data_ok cycle and read data into per-port queues; a monitor thread
// pops and compares on every data_ok pulse.
module tb_cpu_axi_bridge;

`ifdef AXI_RDATA_BYPASS_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 3;
`endif

  logic        clk;
  logic        resetn;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;
  logic [1:0]  rd_state_dbg;
  logic [1:0]  wr_state_dbg;

  cpu_axi_bridge #(.DATA_ARID(4'd1)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_size    (data_sram_size),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .arid              (arid),
    .araddr            (araddr),
    .arsize            (arsize),
    .arvalid           (arvalid),
    .arready           (arready),
    .rdata             (rdata),
    .rvalid            (rvalid),
    .rready            (rready),
    .awaddr            (awaddr),
    .awsize            (awsize),
    .awvalid           (awvalid),
    .awready           (awready),
    .wdata             (wdata),
    .wstrb             (wstrb),
    .wvalid            (wvalid),
    .wready            (wready),
    .bvalid            (bvalid),
    .bready            (bready),
    .rd_state_dbg      (rd_state_dbg),
    .wr_state_dbg      (wr_state_dbg)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  // entry: {compare_rdata, expected data_ok cycle, expected rdata}
  logic [64:0] inst_exp_q[$];
  logic [64:0] data_exp_q[$];
  int checks = 0;
  int errors = 0;
  int aw_cnt = 0;
  int w_cnt  = 0;
  int t0;

  function automatic logic [64:0] mk(input logic chk_data, input int c, input logic [31:0] d);
    logic [31:0] cc;
    cc = c;
    return {chk_data, cc, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    inst_sram_req   = 1'b0;
    inst_sram_addr  = 32'd0;
    data_sram_req   = 1'b0;
    data_sram_wr    = 1'b0;
    data_sram_size  = 2'd0;
    data_sram_addr  = 32'd0;
    data_sram_wstrb = 4'd0;
    data_sram_wdata = 32'd0;
    arready = 1'b0;
    rvalid  = 1'b0;
    rdata   = 32'd0;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    idle_inputs();

    // ---------------- monitor ----------------
    fork
      begin : monitor
        logic [64:0] e;
        forever begin
          @(negedge clk);
          if (inst_sram_data_ok) begin
            if (inst_exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL inst_unexpected_data_ok: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
              e = inst_exp_q.pop_front();
              chk("inst_data_ok_cycle", cyc, e[63:32]);
              chk("inst_rdata", inst_sram_rdata, e[31:0]);
            end
          end
          if (data_sram_data_ok) begin
            if (data_exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL data_unexpected_data_ok: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
              e = data_exp_q.pop_front();
              chk("data_data_ok_cycle", cyc, e[63:32]);
              if (e[64]) chk("data_rdata", data_sram_rdata, e[31:0]);
            end
          end
        end
      end
    join_none

    // ---------------- reset state ----------------
    repeat (3) step();
    settle();
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_bready", bready, 0);
    chk("rst_data_ok", {inst_sram_data_ok, data_sram_data_ok}, 0);
    chk("rst_inst_rdata", inst_sram_rdata, 0);
    chk("rst_data_rdata", data_sram_rdata, 0);
    chk("rst_arid_araddr", {28'd0, arid} | araddr, 0);
    chk("rst_awaddr_wstrb", awaddr | {28'd0, wstrb}, 0);
    chk("rst_fsm_states", {rd_state_dbg, wr_state_dbg}, 0);
    step();
    resetn = 1'b1;

    // ---------------- inst read, minimum latency ----------------
    step();
    inst_sram_req  = 1'b1;
    inst_sram_addr = 32'h1c00_0000;
    settle();
    chk("t1_inst_addr_ok", inst_sram_addr_ok, 1);
    t0 = cyc;
    inst_exp_q.push_back(mk(1'b1, t0 + LAT, 32'h0280_0404));
    step();
    inst_sram_req = 1'b0;
    arready = 1'b1;
    settle();
    chk("t1_arvalid", arvalid, 1);
    chk("t1_arid", arid, 0);
    chk("t1_arsize", arsize, 3'd2);
    chk("t1_araddr", araddr, 32'h1c00_0000);
    step();
    arready = 1'b0;
    rvalid  = 1'b1;
    rdata   = 32'h0280_0404;
    settle();
    chk("t1_rready", rready, 1);
    step();
    rvalid = 1'b0;
    rdata  = 32'd0;
    repeat (2) step();

    // ---------------- inst + data load same cycle ----------------
    inst_sram_req  = 1'b1;
    inst_sram_addr = 32'h1c00_0004;
    data_sram_req  = 1'b1;
    data_sram_wr   = 1'b0;
    data_sram_size = 2'd2;
    data_sram_addr = 32'h0000_1000;
    settle();
    chk("t2_data_addr_ok", data_sram_addr_ok, 1);
    chk("t2_inst_blocked", inst_sram_addr_ok, 0);
    t0 = cyc;
    data_exp_q.push_back(mk(1'b1, t0 + LAT, 32'hdead_beef));
    step();
    data_sram_req = 1'b0;
    arready = 1'b1;
    settle();
    chk("t2_arid_data", arid, 4'd1);
    chk("t2_araddr_data", araddr, 32'h0000_1000);
    chk("t2_inst_wait_ar", inst_sram_addr_ok, 0);
    step();
    arready = 1'b0;
    rvalid  = 1'b1;
    rdata   = 32'hdead_beef;
    settle();
    chk("t2_inst_wait_r", inst_sram_addr_ok, 0);
    step();
    rvalid = 1'b0;
    settle();
    chk("t2_inst_addr_ok", inst_sram_addr_ok, 1);
    t0 = cyc;
    inst_exp_q.push_back(mk(1'b1, t0 + LAT, 32'h1122_3344));
    step();
    inst_sram_req = 1'b0;
    arready = 1'b1;
    settle();
    chk("t2_arid_inst", arid, 4'd0);
    chk("t2_araddr_inst", araddr, 32'h1c00_0004);
    step();
    arready = 1'b0;
    rvalid  = 1'b1;
    rdata   = 32'h1122_3344;
    step();
    rvalid = 1'b0;
    repeat (2) step();

    // ---------------- byte store, W before AW ----------------
    data_sram_req   = 1'b1;
    data_sram_wr    = 1'b1;
    data_sram_size  = 2'd0;
    data_sram_addr  = 32'h0000_0103;
    data_sram_wstrb = 4'b1000;
    data_sram_wdata = 32'hab00_0000;
    settle();
    chk("t3_store_addr_ok", data_sram_addr_ok, 1);
    step();
    data_sram_req = 1'b0;
    data_sram_wr  = 1'b0;
    wready  = 1'b1;
    awready = 1'b0;
    settle();
    chk("t3_awaddr", awaddr, 32'h0000_0103);
    chk("t3_awsize", awsize, 3'd0);
    chk("t3_wstrb", wstrb, 4'b1000);
    chk("t3_wdata", wdata, 32'hab00_0000);
    aw_cnt += int'(awvalid);
    w_cnt  += int'(wvalid);
    step();
    wready = 1'b0;
    settle();
    aw_cnt += int'(awvalid);
    w_cnt  += int'(wvalid);
    step();
    awready = 1'b1;
    settle();
    aw_cnt += int'(awvalid);
    w_cnt  += int'(wvalid);
    step();
    awready = 1'b0;
    bvalid  = 1'b1;
    settle();
    chk("t3_bready", bready, 1);
    chk("t3_aw_w_low_in_b", {awvalid, wvalid}, 0);
    data_exp_q.push_back(mk(1'b0, cyc + 1, 32'd0));
    step();
    bvalid = 1'b0;
    settle();
    chk("t3_awvalid_cycles", aw_cnt, 3);
    chk("t3_wvalid_cycles", w_cnt, 1);
    step();

    // ---------------- load blocked while store sits in W_B ----------------
    data_sram_req   = 1'b1;
    data_sram_wr    = 1'b1;
    data_sram_size  = 2'd2;
    data_sram_addr  = 32'h0000_0200;
    data_sram_wstrb = 4'hf;
    data_sram_wdata = 32'h1234_5678;
    settle();
    chk("t4_store_addr_ok", data_sram_addr_ok, 1);
    step();
    data_sram_req = 1'b0;
    awready = 1'b1;
    wready  = 1'b1;
    settle();
    chk("t4_aw_w_together", {awvalid, wvalid}, 2'b11);
    step();
    awready = 1'b0;
    wready  = 1'b0;
    data_sram_req  = 1'b1;
    data_sram_wr   = 1'b0;
    data_sram_size = 2'd1;
    data_sram_addr = 32'h0000_0302;
    settle();
    chk("t4_in_wb", wr_state_dbg, 2'd2);
    chk("t4_load_blocked_0", data_sram_addr_ok, 0);
    step();
    settle();
    chk("t4_load_blocked_1", data_sram_addr_ok, 0);
    step();
    bvalid = 1'b1;
    settle();
    chk("t4_load_blocked_b", data_sram_addr_ok, 0);
    data_exp_q.push_back(mk(1'b0, cyc + 1, 32'd0));
    step();
    bvalid = 1'b0;
    settle();
    chk("t4_load_addr_ok", data_sram_addr_ok, 1);
    t0 = cyc;
    data_exp_q.push_back(mk(1'b1, t0 + LAT, 32'hcafe_f00d));
    step();
    data_sram_req = 1'b0;
    arready = 1'b1;
    settle();
    chk("t4_arsize_half", arsize, 3'd1);
    chk("t4_araddr", araddr, 32'h0000_0302);
    chk("t4_arid", arid, 4'd1);
    step();
    arready = 1'b0;
    rvalid  = 1'b1;
    rdata   = 32'hcafe_f00d;
    step();
    rvalid = 1'b0;
    repeat (2) step();

    // ---------------- reset while in R_AR ----------------
    inst_sram_req  = 1'b1;
    inst_sram_addr = 32'h1c00_0100;
    settle();
    chk("t5_inst_addr_ok", inst_sram_addr_ok, 1);
    step();
    inst_sram_req = 1'b0;
    settle();
    chk("t5_arvalid_before", arvalid, 1);
    chk("t5_rd_state_ar", rd_state_dbg, 2'd1);
    #1;
    resetn = 1'b0;
    #1;
    chk("t5_arvalid_async", arvalid, 0);
    chk("t5_fsm_idle", {rd_state_dbg, wr_state_dbg}, 0);
    chk("t5_araddr_clr", araddr, 0);
    repeat (2) step();
    resetn = 1'b1;
    step();
    settle();
    chk("t5_arvalid_after", arvalid, 0);

    // ---------------- drain ----------------
    repeat (5) step();
    chk("inst_queue_empty", inst_exp_q.size(), 0);
    chk("data_queue_empty", data_exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
